// File: rtl/uart_imem_loader_if.sv
// rtl/uart_imem_loader_if.sv - UART byte/break inputs and imem/core-control outputs of the boot loader.
interface uart_imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              uart_rx_valid;
  logic [7:0]        uart_rx_data;
  logic              uart_rx_break;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              write_done;
  logic              overflow_err;

  modport master (
    output uart_rx_valid, uart_rx_data, uart_rx_break,
    input  imem_we, imem_addr, imem_wdata, cpu_rst, write_done, overflow_err
  );

  modport slave (
    input  uart_rx_valid, uart_rx_data, uart_rx_break,
    output imem_we, imem_addr, imem_wdata, cpu_rst, write_done, overflow_err
  );
endinterface

// File: rtl/uart_imem_loader.sv
// rtl/uart_imem_loader.sv - assembles UART bytes into little-endian words, writes imem, holds core in reset.
module uart_imem_loader #(
  parameter int          ADDR_W       = 8,
  parameter logic [31:0] END_WORD     = 32'hFFFF_FFFF,
  parameter int          BYTE_TIMEOUT = 2000000
) (
  input  logic                clk,
  input  logic                resetn,
  uart_imem_loader_if.slave   bus
);
  localparam int IDLE_W = $clog2(BYTE_TIMEOUT + 1);

  typedef enum logic [1:0] {LOAD, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] word_addr_q, word_addr_d;
  logic              full_q, full_d;
  logic [31:0]       shift_q, shift_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              overflow_q, overflow_d;
  logic [31:0]       word;

  // The 4th byte is combined with the three already shifted in so the word can be decided on its strobe.
  assign word = {bus.uart_rx_data, shift_q[23:0]};

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_addr_d  = word_addr_q;
    full_d       = full_q;
    shift_d      = shift_q;
    idle_cnt_d   = idle_cnt_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    overflow_d   = overflow_q;
    case (state_q)
      LOAD, WRITE: begin
        if (state_q == WRITE) begin
          state_d = LOAD;
          if (word_addr_q == {ADDR_W{1'b1}}) begin
            full_d = 1'b1;
          end else begin
            word_addr_d = word_addr_q + 1'b1;
          end
        end
        // Break overrides any byte in the same cycle; an in-flight write has already been issued.
        if (bus.uart_rx_break) begin
          byte_cnt_d  = 2'd0;
          word_addr_d = '0;
          full_d      = 1'b0;
          idle_cnt_d  = '0;
        end else if (bus.uart_rx_valid) begin
          idle_cnt_d = '0;
          shift_d[{byte_cnt_q, 3'b000} +: 8] = bus.uart_rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (word == END_WORD) begin
              state_d = DONE;
            end else if (!full_q) begin
              state_d      = WRITE;
              imem_we_d    = 1'b1;
              imem_addr_d  = word_addr_q;
              imem_wdata_d = word;
            end else begin
              overflow_d = 1'b1;
            end
          end
        end else if (byte_cnt_q != 2'd0) begin
          if (idle_cnt_q == IDLE_W'(BYTE_TIMEOUT - 1)) begin
            byte_cnt_d = 2'd0;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end
      end
      DONE: begin
        if (bus.uart_rx_break) begin
          state_d     = LOAD;
          byte_cnt_d  = 2'd0;
          word_addr_d = '0;
          full_d      = 1'b0;
          idle_cnt_d  = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= LOAD;
      byte_cnt_q   <= 2'd0;
      word_addr_q  <= '0;
      full_q       <= 1'b0;
      shift_q      <= '0;
      idle_cnt_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_addr_q  <= word_addr_d;
      full_q       <= full_d;
      shift_q      <= shift_d;
      idle_cnt_q   <= idle_cnt_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.imem_we      = imem_we_q;
  assign bus.imem_addr    = imem_addr_q;
  assign bus.imem_wdata   = imem_wdata_q;
  assign bus.write_done   = (state_q == DONE);
  assign bus.cpu_rst      = (state_q != DONE);
  assign bus.overflow_err = overflow_q;
endmodule
